// File: rtl/cl_reg_bank_decoder.sv
// Camera Link register bank decoder.
// Routes byte writes from the CL front end into NUM_BANKS double-buffered
// register banks (shadow -> active on frame_sync), provides one-cycle
// readback of the shadow registers, and packs byte writes to the table
// addresses of bank TBL_BANK into words for the external timing BRAM.
// DATA_W is expected to be at least 8 (the table pointer is loaded a byte
// at a time) and TBL_ADDR_W at least 8.
module cl_reg_bank_decoder #(
  parameter int NUM_BANKS     = 4,
  parameter int REGS_PER_BANK = 32,
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int IMMEDIATE     = 0,
  parameter int TBL_BANK      = 2,
  parameter int TBL_ADDR_W    = 11,
  parameter int TBL_DATA_W    = 18
) (
  input  logic                                      clk_fix,
  input  logic                                      rst_fix,
  input  logic [NUM_BANKS-1:0]                      bank_wen,
  input  logic [NUM_BANKS-1:0]                      bank_ren,
  input  logic [ADDR_W-1:0]                         reg_addr,
  input  logic [DATA_W-1:0]                         reg_data,
  input  logic                                      frame_sync,
  output logic [NUM_BANKS*REGS_PER_BANK*DATA_W-1:0] active_regs,
  output logic [DATA_W-1:0]                         rd_data,
  output logic                                      rd_valid,
  output logic [NUM_BANKS-1:0]                      bank_dirty,
  output logic                                      tbl_wen,
  output logic [TBL_ADDR_W-1:0]                     tbl_addr,
  output logic [TBL_DATA_W-1:0]                     tbl_din,
  output logic                                      err
);

  localparam int RF_W   = NUM_BANKS * REGS_PER_BANK * DATA_W;
  localparam int BANK_W = REGS_PER_BANK * DATA_W;
  localparam int NBYTES = (TBL_DATA_W + DATA_W - 1) / DATA_W;
  localparam int ASM_W  = NBYTES * DATA_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [ADDR_W-1:0]    NREGS_A     = ADDR_W'(REGS_PER_BANK);
  localparam logic [ADDR_W-1:0]    ADDR_PTR_LO = ADDR_W'(8'hF0);
  localparam logic [ADDR_W-1:0]    ADDR_PTR_HI = ADDR_W'(8'hF1);
  localparam logic [ADDR_W-1:0]    ADDR_BYTE   = ADDR_W'(8'hF2);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NBYTES - 1);
  localparam logic [NUM_BANKS-1:0] TBL_MASK    = NUM_BANKS'(1) << TBL_BANK;

  // Register file: flat vectors, bank b / reg r at [(b*REGS_PER_BANK+r)*DATA_W +: DATA_W]
  logic [RF_W-1:0]        shadow_q, shadow_d;
  logic [RF_W-1:0]        active_q, active_d;
  logic [NUM_BANKS-1:0]   pending_q, pending_d;

  // Readback and error pulse
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_q, err_d;

  // Timing table write port
  logic [TBL_ADDR_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ASM_W-1:0]       asm_q, asm_d;
  logic                   tbl_wen_q, tbl_wen_d;
  logic [TBL_ADDR_W-1:0]  tbl_addr_q, tbl_addr_d;
  logic [TBL_DATA_W-1:0]  tbl_din_q, tbl_din_d;

  // Access decode
  logic [NUM_BANKS-1:0]   strobes;
  logic                   legal;
  logic                   in_range;
  logic                   is_tbl_addr;
  logic                   only_tbl_bank;
  logic                   bad_addr;
  logic                   tbl_hit;
  logic [NUM_BANKS-1:0]   wr_hit;
  logic [NUM_BANKS-1:0]   rd_hit;

  // Classify the current access: legal strobe pattern, target, and address class
  always_comb begin
    strobes       = bank_wen | bank_ren;
    legal         = (strobes & (strobes - NUM_BANKS'(1))) == '0;
    in_range      = reg_addr < NREGS_A;
    is_tbl_addr   = (reg_addr == ADDR_PTR_LO) || (reg_addr == ADDR_PTR_HI) ||
                    (reg_addr == ADDR_BYTE);
    only_tbl_bank = (strobes & ~TBL_MASK) == '0;
    // Table addresses are write-only on the table bank; a read there is silently ignored
    bad_addr      = legal && (strobes != '0) && !in_range &&
                    !(is_tbl_addr && only_tbl_bank);
    tbl_hit       = legal && bank_wen[TBL_BANK] && is_tbl_addr && !in_range;
    wr_hit        = legal ? (bank_wen & {NUM_BANKS{in_range}}) : '0;
    rd_hit        = legal ? (bank_ren & {NUM_BANKS{in_range}}) : '0;
  end

  // Readback mux and error pulse for the next cycle
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = |rd_hit;
    err_d      = !legal || bad_addr;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_hit[b]) begin
        rd_data_d = shadow_q[(b * REGS_PER_BANK + int'(reg_addr)) * DATA_W +: DATA_W];
      end
    end
  end

  // Shadow writes and per-bank commit; a commit always copies the pre-write shadow
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (IMMEDIATE != 0) begin
        active_d[b * BANK_W +: BANK_W] = shadow_q[b * BANK_W +: BANK_W];
        pending_d[b]                   = 1'b0;
      end else begin
        if (frame_sync && pending_q[b]) begin
          active_d[b * BANK_W +: BANK_W] = shadow_q[b * BANK_W +: BANK_W];
        end
        // A write coinciding with frame_sync keeps the bank pending for the next frame
        pending_d[b] = wr_hit[b] || (pending_q[b] && !frame_sync);
      end
      if (wr_hit[b]) begin
        shadow_d[(b * REGS_PER_BANK + int'(reg_addr)) * DATA_W +: DATA_W] = reg_data;
      end
    end
  end

  // Table pointer load, LSB-first byte assembly and word emission
  always_comb begin
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    tbl_wen_d  = 1'b0;
    tbl_addr_d = tbl_addr_q;
    tbl_din_d  = tbl_din_q;
    if (tbl_hit) begin
      if (reg_addr == ADDR_PTR_LO) begin
        for (int i = 0; i < 8; i++) begin
          ptr_d[i] = reg_data[i];
        end
        idx_d = '0;
      end else if (reg_addr == ADDR_PTR_HI) begin
        for (int i = 8; i < TBL_ADDR_W; i++) begin
          ptr_d[i] = reg_data[i - 8];
        end
        idx_d = '0;
      end else begin
        asm_d[int'(idx_q) * DATA_W +: DATA_W] = reg_data;
        if (idx_q == LAST_IDX) begin
          // High bits of the top byte beyond TBL_DATA_W are dropped here
          tbl_wen_d  = 1'b1;
          tbl_addr_d = ptr_q;
          tbl_din_d  = asm_d[TBL_DATA_W-1:0];
          ptr_d      = ptr_q + TBL_ADDR_W'(1);
          idx_d      = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // State registers; reset discards partial table words and pending commits
  always_ff @(posedge clk_fix or posedge rst_fix) begin
    if (rst_fix) begin
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      tbl_wen_q  <= 1'b0;
      tbl_addr_q <= '0;
      tbl_din_q  <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      tbl_wen_q  <= tbl_wen_d;
      tbl_addr_q <= tbl_addr_d;
      tbl_din_q  <= tbl_din_d;
    end
  end

  assign active_regs = active_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign bank_dirty  = pending_q;
  assign tbl_wen     = tbl_wen_q;
  assign tbl_addr    = tbl_addr_q;
  assign tbl_din     = tbl_din_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cl_reg_bank_decoder.sv
// Testbench for cl_reg_bank_decoder (default parameters).
// A behavioural model (register arrays, a byte queue for table words) is
// advanced once per cycle and every DUT output is compared against it.
module tb_cl_reg_bank_decoder;

  localparam int NB = 4;
  localparam int R  = 32;
  localparam int TB = 2;

  logic              clk_fix = 1'b0;
  logic              rst_fix;
  logic [NB-1:0]     bank_wen;
  logic [NB-1:0]     bank_ren;
  logic [7:0]        reg_addr;
  logic [7:0]        reg_data;
  logic              frame_sync;
  logic [NB*R*8-1:0] active_regs;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [NB-1:0]     bank_dirty;
  logic              tbl_wen;
  logic [10:0]       tbl_addr;
  logic [17:0]       tbl_din;
  logic              err;

  cl_reg_bank_decoder dut (
    .clk_fix     (clk_fix),
    .rst_fix     (rst_fix),
    .bank_wen    (bank_wen),
    .bank_ren    (bank_ren),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .frame_sync  (frame_sync),
    .active_regs (active_regs),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .bank_dirty  (bank_dirty),
    .tbl_wen     (tbl_wen),
    .tbl_addr    (tbl_addr),
    .tbl_din     (tbl_din),
    .err         (err)
  );

  always #5 clk_fix = ~clk_fix;

  // Behavioural model state
  logic [7:0]  sh_m [NB][R];
  logic [7:0]  ac_m [NB][R];
  logic [NB-1:0] dirty_m;
  int          ptr_m;
  logic [7:0]  bytes_m [$];
  logic [7:0]  rd_m;
  logic        rv_m, tw_m, err_m;
  logic [10:0] ta_m;
  logic [17:0] td_m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < R; r++) begin
        sh_m[b][r] = 8'h00;
        ac_m[b][r] = 8'h00;
      end
    dirty_m = '0;
    ptr_m   = 0;
    bytes_m.delete();
    rd_m  = 8'h00;
    rv_m  = 1'b0;
    tw_m  = 1'b0;
    err_m = 1'b0;
    ta_m  = '0;
    td_m  = '0;
  endtask

  // One cycle of the specification's rules: read, commit (pre-write shadow), then write
  task automatic model_step(input logic [NB-1:0] w, input logic [NB-1:0] r,
                            input logic [7:0] a, input logic [7:0] d, input logic fs);
    logic [NB-1:0] s;
    int  b;
    bit  single;
    bit  is_tbl;
    s      = w | r;
    rv_m   = 1'b0;
    tw_m   = 1'b0;
    err_m  = 1'b0;
    single = 1'b0;
    is_tbl = 1'b0;
    b      = 0;
    if ($countones(s) > 1) begin
      err_m = 1'b1;
    end else if (s != '0) begin
      single = 1'b1;
      for (int k = 0; k < NB; k++) if (s[k]) b = k;
      is_tbl = (b == TB) && (a >= 8'hF0) && (a <= 8'hF2);
      if (a >= R && !is_tbl) err_m = 1'b1;
      if (r[b] && a < R) begin
        rd_m = sh_m[b][a];
        rv_m = 1'b1;
      end
    end
    for (int k = 0; k < NB; k++) begin
      if (fs && dirty_m[k]) begin
        for (int q = 0; q < R; q++) ac_m[k][q] = sh_m[k][q];
        dirty_m[k] = 1'b0;
      end
    end
    if (single && w[b]) begin
      if (a < R) begin
        sh_m[b][a] = d;
        dirty_m[b] = 1'b1;
      end else if (is_tbl) begin
        if (a == 8'hF0) begin
          ptr_m = (ptr_m & 32'h700) | int'(d);
          bytes_m.delete();
        end else if (a == 8'hF1) begin
          ptr_m = (ptr_m & 32'hFF) | ((int'(d) & 7) << 8);
          bytes_m.delete();
        end else begin
          bytes_m.push_back(d);
          if (bytes_m.size() == 3) begin
            tw_m  = 1'b1;
            ta_m  = 11'(ptr_m);
            td_m  = 18'({bytes_m[2], bytes_m[1], bytes_m[0]});
            ptr_m = (ptr_m + 1) % 2048;
            bytes_m.delete();
          end
        end
      end
    end
  endtask

  // Compare every DUT output with the model
  task automatic check_all();
    logic [NB*R*8-1:0] exp_act;
    int bad_idx;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < R; r++)
        exp_act[(b*R+r)*8 +: 8] = ac_m[b][r];
    n_cmp++;
    if (active_regs !== exp_act) begin
      n_bad++;
      bad_idx = 0;
      for (int i = NB*R-1; i >= 0; i--)
        if (active_regs[i*8 +: 8] !== exp_act[i*8 +: 8]) bad_idx = i;
      $display("FAIL active b%0d r%0d: got 0x%0h, expected 0x%0h (t=%0t)", bad_idx / R, bad_idx % R,
               active_regs[bad_idx*8 +: 8], exp_act[bad_idx*8 +: 8], $time);
    end
    chk("rd_valid", 32'(rd_valid), 32'(rv_m));
    chk("rd_data", 32'(rd_data), 32'(rd_m));
    chk("bank_dirty", 32'(bank_dirty), 32'(dirty_m));
    chk("tbl_wen", 32'(tbl_wen), 32'(tw_m));
    chk("tbl_addr", 32'(tbl_addr), 32'(ta_m));
    chk("tbl_din", 32'(tbl_din), 32'(td_m));
    chk("err", 32'(err), 32'(err_m));
  endtask

  task automatic step(input logic [NB-1:0] w, input logic [NB-1:0] r,
                      input logic [7:0] a, input logic [7:0] d, input logic fs);
    bank_wen   = w;
    bank_ren   = r;
    reg_addr   = a;
    reg_data   = d;
    frame_sync = fs;
    model_step(w, r, a, d, fs);
    @(posedge clk_fix);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bank_wen   = '0;
    bank_ren   = '0;
    reg_addr   = '0;
    reg_data   = '0;
    frame_sync = 1'b0;
    rst_fix    = 1'b1;
    model_reset();
    #2;
    check_all();
    @(posedge clk_fix);
    #1;
    rst_fix = 1'b0;
    check_all();
  endtask

  function automatic logic [7:0] act_byte(input int b, input int r);
    return active_regs[(b*R+r)*8 +: 8];
  endfunction

  initial begin
    logic [NB-1:0] w, r;
    logic [7:0]    a, d;
    logic          fs;
    int            b, b2, sel, x;

    rst_fix = 1'b1;
    bank_wen = '0; bank_ren = '0; reg_addr = '0; reg_data = '0; frame_sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_fix);
    #1;
    check_all();
    chk("rst_active_any", 32'(|active_regs), 32'd0);
    rst_fix = 1'b0;

    // T1: write then commit
    step(4'b0010, 4'b0000, 8'd5, 8'hA5, 1'b0);
    chk("t1_dirty", 32'(bank_dirty), 32'h2);
    chk("t1_active_hold", 32'(act_byte(1, 5)), 32'h00);
    step(4'b0000, 4'b0000, 8'd0, 8'h00, 1'b1);
    chk("t1_active_commit", 32'(act_byte(1, 5)), 32'hA5);
    chk("t1_dirty_clr", 32'(bank_dirty), 32'h0);

    // T2: readback
    step(4'b0000, 4'b0010, 8'd5, 8'h00, 1'b0);
    chk("t2_rv", 32'(rd_valid), 32'h1);
    chk("t2_rd", 32'(rd_data), 32'hA5);
    step(4'b0000, 4'b0000, 8'd0, 8'h00, 1'b0);
    chk("t2_rv_drop", 32'(rd_valid), 32'h0);
    step(4'b0000, 4'b0010, 8'd31, 8'h00, 1'b0);
    chk("t2_rd31", 32'(rd_data), 32'h00);

    // T3: table port with pointer wrap
    step(4'b0100, 4'b0000, 8'hF0, 8'hFE, 1'b0);
    step(4'b0100, 4'b0000, 8'hF1, 8'h07, 1'b0);
    step(4'b0100, 4'b0000, 8'hF2, 8'h34, 1'b0);
    step(4'b0100, 4'b0000, 8'hF2, 8'h12, 1'b0);
    chk("t3_no_wen", 32'(tbl_wen), 32'h0);
    step(4'b0100, 4'b0000, 8'hF2, 8'h03, 1'b0);
    chk("t3_wen", 32'(tbl_wen), 32'h1);
    chk("t3_addr", 32'(tbl_addr), 32'h7FE);
    chk("t3_din", 32'(tbl_din), 32'h31234);
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 8'hF2, 8'(i + 1), 1'b0);
    chk("t3_addr2", 32'(tbl_addr), 32'h7FF);
    chk("t3_din2", 32'(tbl_din), 32'h30201);
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 8'hF2, 8'hFF, 1'b0);
    chk("t3_addr_wrap", 32'(tbl_addr), 32'h000);
    chk("t3_din_trunc", 32'(tbl_din), 32'h3FFFF);
    step(4'b0000, 4'b0000, 8'd0, 8'h00, 1'b0);
    chk("t3_hold_addr", 32'(tbl_addr), 32'h000);

    // T4: illegal strobes and out-of-range address
    step(4'b0011, 4'b0000, 8'd3, 8'h55, 1'b0);
    chk("t4_err_multi", 32'(err), 32'h1);
    chk("t4_dirty_multi", 32'(bank_dirty), 32'h0);
    step(4'b0001, 4'b0000, 8'd200, 8'h66, 1'b0);
    chk("t4_err_oor", 32'(err), 32'h1);
    step(4'b0000, 4'b0001, 8'd3, 8'h00, 1'b0);
    chk("t4_err_clr", 32'(err), 32'h0);
    chk("t4_shadow", 32'(rd_data), 32'h00);

    // T5: write in the frame_sync cycle
    step(4'b0001, 4'b0000, 8'd0, 8'h11, 1'b1);
    chk("t5_active_old", 32'(act_byte(0, 0)), 32'h00);
    chk("t5_dirty", 32'(bank_dirty[0]), 32'h1);
    step(4'b0000, 4'b0000, 8'd0, 8'h00, 1'b1);
    chk("t5_active_new", 32'(act_byte(0, 0)), 32'h11);

    // T6: reset in the middle of a table word
    step(4'b0100, 4'b0000, 8'hF2, 8'hAA, 1'b0);
    step(4'b0100, 4'b0000, 8'hF2, 8'hBB, 1'b0);
    do_reset();
    step(4'b0100, 4'b0000, 8'hF2, 8'h21, 1'b0);
    step(4'b0100, 4'b0000, 8'hF2, 8'h43, 1'b0);
    chk("t6_no_wen", 32'(tbl_wen), 32'h0);
    step(4'b0100, 4'b0000, 8'hF2, 8'h01, 1'b0);
    chk("t6_wen", 32'(tbl_wen), 32'h1);
    chk("t6_addr", 32'(tbl_addr), 32'h000);
    chk("t6_din", 32'(tbl_din), 32'h14321);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      sel = int'($urandom_range(0, 199));
      if (sel == 0) begin
        do_reset();
      end else begin
        w  = '0;
        r  = '0;
        b  = int'($urandom_range(0, NB - 1));
        b2 = (b + 1 + int'($urandom_range(0, NB - 2))) % NB;
        a  = 8'($urandom_range(0, R - 1));
        d  = 8'($urandom);
        fs = ($urandom_range(0, 9) == 0);
        if (sel < 12) begin
          w = NB'(1) << b;
          if ($urandom_range(0, 1) == 1) r = NB'(1) << b2;
          else w = w | (NB'(1) << b2);
        end else if (sel < 30) begin
          w = '0;
        end else if (sel < 120) begin
          w = NB'(1) << b;
        end else begin
          r = NB'(1) << b;
        end
        if (w == (NB'(1) << b) && b == TB && $urandom_range(0, 1) == 0) begin
          x = int'($urandom_range(0, 9));
          a = (x == 0) ? 8'hF0 : (x == 1) ? 8'hF1 : 8'hF2;
        end else if ($urandom_range(0, 9) == 0) begin
          a = 8'($urandom_range(R, 255));
          if (r != '0 && b == TB && a >= 8'hF0 && a <= 8'hF2) a = 8'hF5;
        end
        step(w, r, a, d, fs);
      end
    end

    bank_wen = '0; bank_ren = '0; frame_sync = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
